// File: rtl/operand_fetch.sv
// Operand-fetch stage: 8-entry register file, reads Rn then Rm into the A/B operand
// registers and presents them with the latched shift code under valid/ready.
module operand_fetch #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREG   = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      write,
  input  logic [$clog2(NREG)-1:0]   writenum,
  input  logic [DATA_W-1:0]         data_in,
  input  logic                      start,
  input  logic [$clog2(NREG)-1:0]   rn,
  input  logic [$clog2(NREG)-1:0]   rm,
  input  logic [1:0]                shift_in,
  input  logic                      ready,
  output logic                      busy,
  output logic                      valid,
  output logic [DATA_W-1:0]         aout,
  output logic [DATA_W-1:0]         sin,
  output logic [1:0]                shift
);

  localparam int unsigned IDX_W = $clog2(NREG);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ_A = 2'd1,
    READ_B = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   rn_q;
  logic [IDX_W-1:0]   rm_q;
  logic [DATA_W-1:0]  regs [NREG];

  // Status flags decode straight from the state register.
  assign busy  = (state != IDLE);
  assign valid = (state == HOLD);

  // Register file, fetch sequencing and operand registers; a same-cycle write to the
  // register being read is forwarded so the operand never picks up the stale entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rn_q  <= '0;
      rm_q  <= '0;
      aout  <= '0;
      sin   <= '0;
      shift <= 2'b00;
      for (int i = 0; i < int'(NREG); i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (write) begin
        regs[writenum] <= data_in;
      end
      case (state)
        IDLE: begin
          if (start) begin
            rn_q  <= rn;
            rm_q  <= rm;
            shift <= shift_in;
            state <= READ_A;
          end
        end
        READ_A: begin
          aout  <= (write && (writenum == rn_q)) ? data_in : regs[rn_q];
          state <= READ_B;
        end
        READ_B: begin
          sin   <= (write && (writenum == rm_q)) ? data_in : regs[rm_q];
          state <= HOLD;
        end
        HOLD: begin
          if (ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Testbench for operand_fetch: directed scenarios plus randomized fetches checked
// against an array model of the register file with fixed fetch latency.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        write;
  logic [2:0]  writenum;
  logic [15:0] data_in;
  logic        start;
  logic [2:0]  rn;
  logic [2:0]  rm;
  logic [1:0]  shift_in;
  logic        ready;
  logic        busy;
  logic        valid;
  logic [15:0] aout;
  logic [15:0] sin;
  logic [1:0]  shift;

  logic [15:0] ref_r [8];
  int checks = 0;
  int errors = 0;

  operand_fetch dut (
    .clk      (clk),
    .reset    (reset),
    .write    (write),
    .writenum (writenum),
    .data_in  (data_in),
    .start    (start),
    .rn       (rn),
    .rm       (rm),
    .shift_in (shift_in),
    .ready    (ready),
    .busy     (busy),
    .valid    (valid),
    .aout     (aout),
    .sin      (sin),
    .shift    (shift)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge; the model applies the inputs presented at that edge.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 8; i++) ref_r[i] = 16'h0000;
    end else if (write) begin
      ref_r[writenum] = data_in;
    end
    #1;
  endtask

  task automatic rand_write();
    write    = 1'($urandom_range(0, 1));
    writenum = 3'($urandom);
    data_in  = 16'($urandom);
  endtask

  task automatic wr(input logic [2:0] idx, input logic [15:0] val);
    write = 1'b1; writenum = idx; data_in = val;
    tick();
    write = 1'b0;
  endtask

  // Full fetch: operands must equal register contents as they stand after the
  // READ_A / READ_B edges (write-through included), valid exactly after edge k+2.
  task automatic do_fetch(input logic [2:0] a, input logic [2:0] b, input logic [1:0] sh,
                          input int hold, input bit rnd, input string tag);
    logic [15:0] ea;
    logic [15:0] eb;
    rn = a; rm = b; shift_in = sh; start = 1'b1;
    ready = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
    if (rnd) rand_write(); else write = 1'b0;
    tick();
    chk({tag, " busy_k"}, 32'(busy), 32'd1);
    chk({tag, " valid_k"}, 32'(valid), 32'd0);

    start = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
    rn = 3'($urandom); rm = 3'($urandom); shift_in = 2'($urandom);
    ready = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
    if (rnd) rand_write();
    tick();
    ea = ref_r[a];
    chk({tag, " aout_k1"}, 32'(aout), 32'(ea));
    chk({tag, " valid_k1"}, 32'(valid), 32'd0);

    start = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
    ready = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
    if (rnd) rand_write();
    tick();
    eb = ref_r[b];
    chk({tag, " valid_k2"}, 32'(valid), 32'd1);
    chk({tag, " aout_k2"}, 32'(aout), 32'(ea));
    chk({tag, " sin_k2"}, 32'(sin), 32'(eb));
    chk({tag, " shift_k2"}, 32'(shift), 32'(sh));

    ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      start = 1'b1; rn = 3'($urandom); rm = 3'($urandom); shift_in = 2'($urandom);
      if (rnd) rand_write(); else write = 1'b0;
      tick();
      chk({tag, " hold_valid"}, 32'(valid), 32'd1);
      chk({tag, " hold_aout"}, 32'(aout), 32'(ea));
      chk({tag, " hold_sin"}, 32'(sin), 32'(eb));
      chk({tag, " hold_shift"}, 32'(shift), 32'(sh));
    end

    // Accept with start also high: that start lands while busy and must be dropped.
    ready = 1'b1; start = 1'b1;
    if (rnd) rand_write(); else write = 1'b0;
    tick();
    chk({tag, " done_valid"}, 32'(valid), 32'd0);
    chk({tag, " done_busy"}, 32'(busy), 32'd0);
    chk({tag, " done_aout"}, 32'(aout), 32'(ea));
    chk({tag, " done_sin"}, 32'(sin), 32'(eb));
    chk({tag, " done_shift"}, 32'(shift), 32'(sh));

    start = 1'b0; ready = 1'b0; write = 1'b0;
    tick();
    chk({tag, " idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b0; write = 1'b0; writenum = 3'd0; data_in = 16'h0000;
    start = 1'b0; rn = 3'd0; rm = 3'd0; shift_in = 2'b00; ready = 1'b0;
    for (int i = 0; i < 8; i++) ref_r[i] = 16'hxxxx;

    // Reset overrides a simultaneous start and write.
    reset = 1'b1; start = 1'b1; write = 1'b1; writenum = 3'd2; data_in = 16'hFFFF;
    tick();
    reset = 1'b0; start = 1'b0; write = 1'b0;
    chk("rst aout", 32'(aout), 32'h0000);
    chk("rst sin", 32'(sin), 32'h0000);
    chk("rst shift", 32'(shift), 32'd0);
    chk("rst valid", 32'(valid), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    tick();
    chk("rst idle", 32'(busy), 32'd0);
    do_fetch(3'd3, 3'd5, 2'b10, 0, 1'b0, "zero");

    // Basic fetch, then the same fetch under backpressure.
    wr(3'd1, 16'h1234);
    wr(3'd2, 16'h00F0);
    do_fetch(3'd1, 3'd2, 2'b01, 0, 1'b0, "basic");
    chk("basic R1", 32'(ref_r[1]), 32'h1234);
    do_fetch(3'd1, 3'd2, 2'b01, 5, 1'b0, "bp");

    // Write-through bypass on both read cycles of the same register.
    wr(3'd4, 16'h1111);
    rn = 3'd4; rm = 3'd4; shift_in = 2'b00; start = 1'b1;
    tick();
    start = 1'b0; write = 1'b1; writenum = 3'd4; data_in = 16'hBEEF;
    tick();
    chk("byp aout", 32'(aout), 32'hBEEF);
    data_in = 16'hCAFE;
    tick();
    write = 1'b0;
    chk("byp aout2", 32'(aout), 32'hBEEF);
    chk("byp sin", 32'(sin), 32'hCAFE);
    chk("byp valid", 32'(valid), 32'd1);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("byp busy", 32'(busy), 32'd0);
    do_fetch(3'd4, 3'd4, 2'b00, 0, 1'b0, "byp_r4");
    chk("byp R4 model", 32'(ref_r[4]), 32'hCAFE);

    // Reset in READ_B aborts the fetch and clears the register file.
    wr(3'd5, 16'h5555);
    rn = 3'd5; rm = 3'd5; shift_in = 2'b11; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("mid aout pre", 32'(aout), 32'h5555);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid valid", 32'(valid), 32'd0);
    chk("mid busy", 32'(busy), 32'd0);
    chk("mid aout", 32'(aout), 32'h0000);
    chk("mid sin", 32'(sin), 32'h0000);
    chk("mid shift", 32'(shift), 32'd0);
    tick();
    chk("mid idle", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) do_fetch(3'(i), 3'(7 - i), 2'b00, 0, 1'b0, "mid_zero");
    do_fetch(3'd5, 3'd5, 2'b00, 0, 1'b0, "mid_r5");

    // Index extremes.
    wr(3'd0, 16'h8001);
    wr(3'd7, 16'h7FFE);
    do_fetch(3'd7, 3'd0, 2'b11, 2, 1'b0, "ext");
    chk("ext aout", 32'(aout), 32'h7FFE);
    chk("ext sin", 32'(sin), 32'h8001);

    // Randomized fetches with writes landing in every phase.
    for (int i = 0; i < 8; i++) wr(3'(i), 16'($urandom));
    for (int n = 0; n < 40; n++) begin
      do_fetch(3'($urandom), 3'($urandom), 2'($urandom), int'($urandom_range(0, 3)), 1'b1, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
